// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store engine: access types, FSM states,
// the registered request record and the alignment/legality rule.
package mem_access_unit_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        MAU_IDLE = 2'd0,
        MAU_WAIT = 2'd1,
        MAU_DONE = 2'd2
    } mau_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  dm_type;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mau_req_t;

    // Unsigned variants share the alignment rule of their signed twins.
    function automatic logic dm_legal(input logic [2:0] t, input logic [1:0] off);
        case (t)
            DM_WORD:              return (off == 2'b00);
            DM_HALF, DM_HALF_U:   return !off[0];
            DM_BYTE, DM_BYTE_U:   return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Combinational lane logic: byte enables and store replication for the bus,
// lane select plus sign/zero extension for load data.
module dm_lane_ext
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  dm_type,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] ld_ext,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ld_ext    = rdata;
        be        = 4'b1111;
        wdata_rep = wdata;
        case (dm_type)
            DM_HALF, DM_HALF_U: begin
                ld_ext    = {{16{half_lane[15] & (dm_type == DM_HALF)}}, half_lane};
                be        = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            DM_BYTE, DM_BYTE_U: begin
                ld_ext    = {{24{byte_lane[7] & (dm_type == DM_BYTE)}}, byte_lane};
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one word-aligned bus transaction per access,
// stalls the pipeline until ack or timeout, and returns the extended load result.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  dm_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    mau_state_e       state, state_nxt;
    mau_req_t         req_q;
    logic [CNT_W-1:0] cnt;
    logic             access, legal, start, illegal, ack_hit, tmo_hit, stall_c;
    logic [31:0]      ld_ext, wdata_rep;
    logic [3:0]       be_lane;

    // Lane logic runs off the registered request so the bus stays stable in WAIT.
    dm_lane_ext u_lane (
        .dm_type   (req_q.dm_type),
        .offset    (req_q.addr[1:0]),
        .rdata     (bus_rdata),
        .wdata     (req_q.wdata),
        .ld_ext    (ld_ext),
        .be        (be_lane),
        .wdata_rep (wdata_rep)
    );

    assign access = mem_read | mem_write;
    assign legal  = dm_legal(dm_type, addr[1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= MAU_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        start     = 1'b0;
        illegal   = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            MAU_IDLE: begin
                if (access && legal) begin
                    start     = 1'b1;
                    stall_c   = 1'b1;
                    state_nxt = MAU_WAIT;
                end else if (access) begin
                    illegal = 1'b1;
                end
            end
            MAU_WAIT: begin
                stall_c = 1'b1;
                if (bus_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = MAU_DONE;
                end else if (TIMEOUT > 0 && cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = MAU_DONE;
                end
            end
            // DONE never stalls, so the instruction leaves MEM at this edge.
            default: state_nxt = MAU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q    <= '0;
            cnt      <= '0;
            ld_valid <= 1'b0;
            ld_data  <= '0;
            mem_err  <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            mem_err  <= 1'b0;
            if (start) begin
                req_q <= '{we: mem_write, dm_type: dm_type, addr: addr, wdata: wdata};
                cnt   <= '0;
            end
            if (illegal) begin
                mem_err  <= 1'b1;
                ld_valid <= ~mem_write;
                if (!mem_write) ld_data <= '0;
            end
            if (ack_hit) begin
                ld_valid <= ~req_q.we;
                if (!req_q.we) ld_data <= ld_ext;
            end else if (tmo_hit) begin
                mem_err  <= 1'b1;
                ld_valid <= ~req_q.we;
                if (!req_q.we) ld_data <= '0;
            end else if (state == MAU_WAIT && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Gated by rstn so the stage releases the moment reset is asserted.
    assign stall     = stall_c & rstn;
    assign bus_req   = (state == MAU_WAIT);
    assign bus_we    = req_q.we;
    assign bus_addr  = {req_q.addr[31:2], 2'b00};
    assign bus_be    = req_q.we ? be_lane : 4'b0000;
    assign bus_wdata = req_q.we ? wdata_rep : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): load extension, store lanes,
// illegal accesses, timeout, back-to-back ordering and asynchronous reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_read, mem_write;
    logic [2:0]  dm_type;
    logic [31:0] addr, wdata;
    logic        stall, ld_valid, mem_err;
    logic [31:0] ld_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int pass_cnt = 0;
    int total    = 0;

    // Observations gathered by run_access for the calling test to judge.
    int          obs_stall, obs_req, obs_bursts, obs_nv, obs_ne;
    logic [31:0] obs_data, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_hold_bad, obs_hung;
    logic [31:0] burst_addr_q[$];

    mem_access_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rstn(rstn), .mem_read(mem_read), .mem_write(mem_write),
        .dm_type(dm_type), .addr(addr), .wdata(wdata), .stall(stall),
        .ld_valid(ld_valid), .ld_data(ld_data), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Present one instruction, answer the bus after ack_at WAIT cycles (-1: never),
    // and observe until the cycle after the stage is released.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] t,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rword, input int ack_at);
        bit   left = 1'b0;
        logic prev_req = 1'b0;
        int   k = 0;
        obs_stall = 0; obs_req = 0; obs_bursts = 0; obs_nv = 0; obs_ne = 0;
        obs_data = 32'hDEAD_BEEF; obs_addr = 0; obs_wdata = 0; obs_be = 0; obs_we = 0;
        obs_hold_bad = 0; obs_hung = 1;
        @(negedge clk);
        mem_read = rd; mem_write = wr; dm_type = t; addr = a; wdata = wd;
        bus_ack = 0; bus_rdata = 0;
        while (k < 40) begin
            #1;
            if (stall) obs_stall++;
            if (bus_req && !prev_req) begin
                obs_bursts++;
                burst_addr_q.push_back(bus_addr);
            end
            prev_req = bus_req;
            if (bus_req) begin
                if (obs_req == 0) begin
                    obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; obs_we = bus_we;
                end else if (bus_addr !== obs_addr || bus_be !== obs_be ||
                             bus_wdata !== obs_wdata || bus_we !== obs_we) begin
                    obs_hold_bad = 1;
                end
                if (obs_req == ack_at) begin
                    bus_ack = 1; bus_rdata = rword;
                end
                obs_req++;
            end
            if (ld_valid) begin obs_nv++; obs_data = ld_data; end
            if (mem_err) obs_ne++;
            if (left) begin obs_hung = 0; break; end
            if (!stall) left = 1;
            @(negedge clk);
            bus_ack = 0;
            if (left) begin mem_read = 0; mem_write = 0; end
            k++;
        end
        mem_read = 0; mem_write = 0; bus_ack = 0;
    endtask

    task automatic test_reset();
        rstn = 0; mem_read = 0; mem_write = 0; dm_type = 0; addr = 0; wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({stall, ld_valid, mem_err, bus_req, bus_we} !== 5'b0 || ld_data !== 0 ||
            bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0)
            $display("FAIL reset_outputs: got stall=%b lv=%b err=%b req=%b we=%b data=%h addr=%h be=%b wd=%h want all 0",
                     stall, ld_valid, mem_err, bus_req, bus_we, ld_data, bus_addr, bus_be, bus_wdata);
        else pass_cnt++;
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_load_ext();
        run_access(1, 0, 3'b011, 32'h103, 0, 32'h80FF_1234, 0);
        total++; if (obs_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", obs_data); else pass_cnt++;
        total++; if (obs_addr !== 32'h100) $display("FAIL lb_bus_addr: got %h want 00000100", obs_addr); else pass_cnt++;
        total++; if (obs_be !== 4'b0000 || obs_we !== 0) $display("FAIL lb_be_we: got be=%b we=%b want 0000/0", obs_be, obs_we); else pass_cnt++;
        total++; if (obs_stall !== 2) $display("FAIL lb_stall_cycles: got %0d want 2", obs_stall); else pass_cnt++;
        total++; if (obs_nv !== 1 || obs_ne !== 0) $display("FAIL lb_pulses: got valid=%0d err=%0d want 1/0", obs_nv, obs_ne); else pass_cnt++;
        run_access(1, 0, 3'b010, 32'h202, 0, 32'hBEEF_0001, 0);
        total++; if (obs_data !== 32'h0000_BEEF) $display("FAIL lhu_data: got %h want 0000beef", obs_data); else pass_cnt++;
        run_access(1, 0, 3'b001, 32'h202, 0, 32'hBEEF_0001, 0);
        total++; if (obs_data !== 32'hFFFF_BEEF) $display("FAIL lh_data: got %h want ffffbeef", obs_data); else pass_cnt++;
        run_access(1, 0, 3'b100, 32'h101, 0, 32'h0000_9A00, 1);
        total++; if (obs_data !== 32'h0000_009A) $display("FAIL lbu_data: got %h want 0000009a", obs_data); else pass_cnt++;
    endtask

    task automatic test_store_lanes();
        run_access(0, 1, 3'b011, 32'h301, 32'h1234_56AB, 0, 0);
        total++; if (obs_be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", obs_be); else pass_cnt++;
        total++; if (obs_wdata !== 32'hABAB_ABAB) $display("FAIL sb_wdata: got %h want abababab", obs_wdata); else pass_cnt++;
        total++; if (obs_we !== 1 || obs_nv !== 0) $display("FAIL sb_we_novalid: got we=%b valid=%0d want 1/0", obs_we, obs_nv); else pass_cnt++;
        run_access(0, 1, 3'b001, 32'h302, 32'h1234_56AB, 0, 0);
        total++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h56AB_56AB) $display("FAIL sh_lanes: got be=%b wd=%h want 1100/56ab56ab", obs_be, obs_wdata); else pass_cnt++;
        // Both strobes set: the write wins.
        run_access(1, 1, 3'b000, 32'h340, 32'h0BAD_F00D, 32'h1, 0);
        total++; if (obs_we !== 1 || obs_be !== 4'b1111 || obs_nv !== 0) $display("FAIL rw_write_wins: got we=%b be=%b valid=%0d want 1/1111/0", obs_we, obs_be, obs_nv); else pass_cnt++;
    endtask

    task automatic test_illegal();
        run_access(1, 0, 3'b000, 32'h402, 0, 0, 0);
        total++; if (obs_req !== 0 || obs_stall !== 0) $display("FAIL lw_mis_nobus: got req=%0d stall=%0d want 0/0", obs_req, obs_stall); else pass_cnt++;
        total++; if (obs_ne !== 1 || obs_nv !== 1 || obs_data !== 0) $display("FAIL lw_mis_resp: got err=%0d valid=%0d data=%h want 1/1/0", obs_ne, obs_nv, obs_data); else pass_cnt++;
        run_access(1, 0, 3'b100, 32'h403, 0, 32'hFF00_0000, 0);
        run_access(1, 0, 3'b111, 32'h400, 0, 0, 0);
        total++; if (obs_req !== 0 || obs_stall !== 0 || obs_ne !== 1 || obs_nv !== 1 || obs_data !== 0)
            $display("FAIL dm111_resp: got req=%0d stall=%0d err=%0d valid=%0d data=%h want 0/0/1/1/0", obs_req, obs_stall, obs_ne, obs_nv, obs_data);
        else pass_cnt++;
        run_access(0, 1, 3'b001, 32'h405, 32'h1, 0, 0);
        total++; if (obs_req !== 0 || obs_ne !== 1 || obs_nv !== 0) $display("FAIL sh_mis_resp: got req=%0d err=%0d valid=%0d want 0/1/0", obs_req, obs_ne, obs_nv); else pass_cnt++;
    endtask

    task automatic test_timeout();
        run_access(1, 0, 3'b000, 32'h600, 0, 32'h1111_2222, 0);
        run_access(1, 0, 3'b000, 32'h604, 0, 32'h7777_7777, -1);
        total++; if (obs_req !== 4 || obs_hung) $display("FAIL tmo_req_cycles: got %0d hung=%b want 4/0", obs_req, obs_hung); else pass_cnt++;
        total++; if (obs_ne !== 1 || obs_nv !== 1 || obs_data !== 0) $display("FAIL tmo_resp: got err=%0d valid=%0d data=%h want 1/1/0", obs_ne, obs_nv, obs_data); else pass_cnt++;
        run_access(1, 0, 3'b000, 32'h608, 0, 32'h5A5A_0000, 3);
        total++; if (obs_req !== 4 || obs_ne !== 0 || obs_data !== 32'h5A5A_0000) $display("FAIL tmo_ack_wins: got req=%0d err=%0d data=%h want 4/0/5a5a0000", obs_req, obs_ne, obs_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        burst_addr_q.delete();
        run_access(0, 1, 3'b000, 32'h500, 32'hCAFE_F00D, 0, 3);
        total++; if (obs_bursts !== 1 || obs_req !== 4 || obs_stall !== 5) $display("FAIL b2b_sw_burst: got bursts=%0d req=%0d stall=%0d want 1/4/5", obs_bursts, obs_req, obs_stall); else pass_cnt++;
        total++; if (obs_be !== 4'b1111 || obs_wdata !== 32'hCAFE_F00D || obs_hold_bad) $display("FAIL b2b_sw_bus: got be=%b wd=%h unstable=%b want 1111/cafef00d/0", obs_be, obs_wdata, obs_hold_bad); else pass_cnt++;
        run_access(1, 0, 3'b000, 32'h504, 0, 32'h1122_3344, 3);
        total++; if (obs_bursts !== 1 || obs_data !== 32'h1122_3344 || obs_hold_bad) $display("FAIL b2b_lw: got bursts=%0d data=%h unstable=%b want 1/11223344/0", obs_bursts, obs_data, obs_hold_bad); else pass_cnt++;
        total++;
        if (burst_addr_q.size() != 2 || burst_addr_q[0] !== 32'h500 || burst_addr_q[1] !== 32'h504)
            $display("FAIL b2b_order: got %0d bursts want 2 (500 then 504)", burst_addr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_ack_ignored();
        int bad = 0;
        @(negedge clk);
        bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk); #1;
            if (bus_req || stall || ld_valid || mem_err) bad++;
        end
        bus_ack = 0;
        total++; if (bad !== 0) $display("FAIL idle_ack: got %0d active cycles want 0", bad); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        mem_read = 1; dm_type = 3'b000; addr = 32'h700;
        @(negedge clk); #1;
        total++; if (bus_req !== 1) $display("FAIL rst_pre_wait: got req=%b want 1", bus_req); else pass_cnt++;
        rstn = 0; #1;
        total++; if (bus_req !== 0 || stall !== 0) $display("FAIL rst_async_drop: got req=%b stall=%b want 0/0", bus_req, stall); else pass_cnt++;
        mem_read = 0;
        @(negedge clk); rstn = 1;
        @(negedge clk); #1;
        total++; if (bus_req !== 0 || stall !== 0 || ld_valid !== 0) $display("FAIL rst_idle_after: got req=%b stall=%b valid=%b want 0/0/0", bus_req, stall, ld_valid); else pass_cnt++;
        run_access(1, 0, 3'b011, 32'h103, 0, 32'h80FF_1234, 0);
        total++; if (obs_data !== 32'hFFFF_FF80 || obs_stall !== 2) $display("FAIL rst_recover: got data=%h stall=%0d want ffffff80/2", obs_data, obs_stall); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_lanes();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_ack_ignored();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
